serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 1..32).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured on the accepted start edge.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured on the accepted start edge.
REQ-007 SHALL have port cin  input  1  carry-in, captured on the accepted start edge.
REQ-008 SHALL have port busy  output  1  high while bits are being processed (RUN).
REQ-009 SHALL have port done  output  1  one-cycle pulse when sum/cout become valid.
REQ-010 SHALL have port sum  output  WIDTH  registered result, A+B+cin modulo 2^WIDTH.
REQ-011 SHALL have port cout  output  1  registered carry-out of bit WIDTH-1.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE.
REQ-013 IDLE: start=1 SHALL capture a, b into operand shift registers, cin into the carry flop, clear the bit counter, and enter RUN.
REQ-014 IDLE: start=0 SHALL hold all state and outputs.
REQ-015 RUN: each cycle SHALL feed operand LSBs and the carry flop into one full-adder instance, shift Sout into the result shift register at its MSB, load Cout into the carry flop, shift the operands right by one, and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH cycles: when the counter equals WIDTH-1, the next state SHALL be DONE.
REQ-017 Entering DONE SHALL copy the result shift register to sum and the carry flop to cout in the same edge.
REQ-018 sum and cout SHALL not change during RUN; they SHALL hold the prior result until the next DONE.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-020 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both are decoded from registered state.
REQ-021 start in RUN or DONE SHALL be ignored (no queueing); a start held high SHALL be re-accepted only after returning to IDLE.
REQ-022 Latency: start accepted at edge k SHALL yield busy for cycles k+1..k+WIDTH and done in cycle k+WIDTH+1; sustained throughput is one result per WIDTH+2 cycles.
REQ-023 a, b and cin changes after the accepting edge SHALL have no effect on the current operation.
REQ-024 WIDTH=1 SHALL reduce to a single RUN cycle and produce the one-bit full-adder truth table.

Reset
REQ-025 rst=1 SHALL force IDLE and clear the operand, result and carry registers, counter, sum and cout to 0. busy and done SHALL be 0.
REQ-026 rst SHALL take priority over start and over every state transition, including mid-RUN.
REQ-027 rst asserted mid-RUN SHALL abort without a done pulse. The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-028 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default SHALL live in shared package/include serial_add_pkg.
REQ-029 SHALL instantiate exactly one one_bit_adder (ports A1, B1, Cin, Cout, Sout) as its only sub-module; no other arithmetic is permitted in the datapath.
REQ-030 Counter width SHALL be clog2(WIDTH) with a 1-bit minimum.

Verification (WIDTH=8 unless stated)
REQ-031 a=0x00, b=0x00, cin=0, start -> busy for 8 cycles, done 9 cycles after the start edge, sum=0x00, cout=0.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0.
REQ-033 a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; sum keeps the previous result throughout RUN.
REQ-034 start held high for 30 cycles, a=0x03, b=0x04 -> results every 10 cycles, each sum=0x07, one done per operation; mid-RUN operand changes ignored.
REQ-035 rst=1 on the 4th RUN cycle -> next cycle IDLE, busy=0, sum=0x00, cout=0, no done; a following start with a=0x10, b=0x20 -> sum=0x30.
REQ-036 WIDTH=1: all 8 (a, b, cin) combinations -> {cout, sum} equals a+b+cin, done 2 cycles after each start.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings, default width and
// the counter-width helper.
package serial_add_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit counter needs clog2(width) bits, never fewer than one.
  function automatic int cnt_w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/one_bit_adder.sv
// Single full-adder cell; the only arithmetic in the serial datapath.
module one_bit_adder (
  input  logic A1,
  input  logic B1,
  input  logic Cin,
  output logic Cout,
  output logic Sout
);

  logic p;

  assign p    = A1 ^ B1;
  assign Sout = p ^ Cin;
  assign Cout = (A1 & B1) | (Cin & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell is reused WIDTH times, LSB first,
// with the result landing in registered sum/cout on a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] opa, opb, res;
  logic [WIDTH-1:0] opa_sh, opb_sh, res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;

  one_bit_adder u_fa (
    .A1   (opa[0]),
    .B1   (opb[0]),
    .Cin  (carry),
    .Cout (fa_c),
    .Sout (fa_s)
  );

  // Next-shift values; the one-bit case has no upper bits to move down.
  generate
    if (WIDTH == 1) begin : g_w1
      assign opa_sh = '0;
      assign opb_sh = '0;
      assign res_sh = fa_s;
    end else begin : g_wn
      assign opa_sh = {1'b0, opa[WIDTH-1:1]};
      assign opb_sh = {1'b0, opb[WIDTH-1:1]};
      assign res_sh = {fa_s, res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          opa   <= opa_sh;
          opb   <= opb_sh;
          res   <= res_sh;
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          // Publish the shifted-in final bit and carry directly, since res and
          // carry only hold them after this same edge.
          if (cnt == CNT_LAST) begin
            sum   <= res_sh;
            cout  <= fa_c;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed + random bench for serial_add_ctrl at WIDTH=8 and WIDTH=1, checked
// against plain integer addition.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic start1, a1, b1, cin1;
  logic busy1, done1, sum1, cout1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] prev_sum;
  logic       prev_cout;
  int         n_done;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation on the 8-bit instance, scrambling inputs after acceptance.
  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc);
    logic [8:0] exp9;
    exp9 = {1'b0, oa} + {1'b0, ob} + {8'd0, oc};
    a = oa; b = ob; cin = oc; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_sum_hold", sum, prev_sum);
      chk("run_cout_hold", cout, prev_cout);
      step();
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("sum", sum, exp9[7:0]);
    chk("cout", cout, exp9[8]);
    step();
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
    prev_sum = exp9[7:0];
    prev_cout = exp9[8];
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    rst = 1'b0;
    step();
    chk("idle_hold_busy", busy, 0);
    chk("idle_hold_sum", sum, 0);
    prev_sum = 8'h00; prev_cout = 1'b0;

    run_op(8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1);
    for (int r = 0; r < 20; r++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom));

    // start held high: one acceptance every 10 cycles, 3/4 only at accept edges
    n_done = 0;
    for (int t = 1; t <= 30; t++) begin
      start = 1'b1;
      if ((t - 1) % 10 == 0) begin
        a = 8'h03; b = 8'h04; cin = 1'b0;
      end else begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
      step();
      chk("held_busy", busy, ((t - 1) % 10) < 8);
      chk("held_done", done, (t % 10) == 9);
      if ((t % 10) == 9) begin
        chk("held_sum", sum, 8'h07);
        chk("held_cout", cout, 0);
      end
      if (done) n_done++;
    end
    start = 1'b0;
    step();
    chk("held_idle", busy, 0);
    chk("held_ndone", n_done, 3);
    prev_sum = 8'h07; prev_cout = 1'b0;

    // reset on the 4th RUN cycle
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("abort_pre_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("abort_no_done", done, 0);
    end
    prev_sum = 8'h00; prev_cout = 1'b0;
    run_op(8'h10, 8'h20, 1'b0);

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; cin1 = i[0]; start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk("w1_busy", busy1, 1);
      chk("w1_done_early", done1, 0);
      step();
      chk("w1_done", done1, 1);
      chk("w1_result", {cout1, sum1}, i[2] + i[1] + i[0]);
      step();
      chk("w1_done_clear", done1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
